// File: rtl/arith_pkg.sv
// Shared types and helpers for the multicycle arithmetic units.
package arith_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  localparam int SLICE_W = 8;

  // Counter width for n slices; never below one bit so a 1-slice unit still has an idx flop.
  function automatic int clog2(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/byte_add_slice.sv
// Combinational 8-bit adder slice; also exposes the carry into the top bit.
module byte_add_slice
  import arith_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               cout,
  output logic               c7
);

  logic [SLICE_W:0]   full;
  logic [SLICE_W-1:0] low;

  assign full = {1'b0, a} + {1'b0, b} + {{SLICE_W{1'b0}}, cin};
  assign low  = {1'b0, a[SLICE_W-2:0]} + {1'b0, b[SLICE_W-2:0]} + {{(SLICE_W-1){1'b0}}, cin};

  assign sum  = full[SLICE_W-1:0];
  assign cout = full[SLICE_W];
  assign c7   = low[SLICE_W-1];

endmodule

// File: rtl/byte_serial_adder_ctrl.sv
// WIDTH-bit add/subtract sequenced LSB-first over one shared 8-bit slice.
module byte_serial_adder_ctrl
  import arith_pkg::*;
#(
  parameter int N_BYTES = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   ctrl_sub,
  input  logic [8*N_BYTES-1:0]   data_operandA,
  input  logic [8*N_BYTES-1:0]   data_operandB,
  output logic                   busy,
  output logic                   done,
  output logic [8*N_BYTES-1:0]   data_result,
  output logic                   cout,
  output logic                   overflow
);

  localparam int WIDTH = SLICE_W * N_BYTES;
  localparam int IDX_W = clog2(N_BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BYTES - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]   opa_q, opa_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               accept;
  logic               last;
  logic [SLICE_W-1:0] sl_a, sl_b, sl_sum;
  logic               sl_cout, sl_c7;

  assign accept = start && (state_q != RUN);
  assign last   = (idx_q == LAST_IDX);
  assign sl_a   = opa_q[idx_q*SLICE_W +: SLICE_W];
  assign sl_b   = opb_q[idx_q*SLICE_W +: SLICE_W];

  byte_add_slice u_slice (
    .a    (sl_a),
    .b    (sl_b),
    .cin  (carry_q),
    .sum  (sl_sum),
    .cout (sl_cout),
    .c7   (sl_c7)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      acc_q    <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      acc_q    <= acc_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last)  state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Subtract is A + ~B + 1: the +1 rides in as the initial carry.
  always_comb begin
    idx_d    = idx_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    acc_d    = acc_q;
    carry_d  = carry_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    if (accept) begin
      opa_d   = data_operandA;
      opb_d   = ctrl_sub ? ~data_operandB : data_operandB;
      carry_d = ctrl_sub;
      idx_d   = '0;
      acc_d   = '0;
    end else if (state_q == RUN) begin
      acc_d[idx_q*SLICE_W +: SLICE_W] = sl_sum;
      carry_d = sl_cout;
      idx_d   = last ? '0 : idx_q + 1'b1;
      if (last) begin
        result_d = acc_d;
        cout_d   = sl_cout;
        ovf_d    = sl_c7 ^ sl_cout;
      end
    end
  end

  always_comb begin
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign data_result = result_q;
  assign cout        = cout_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_byte_serial_adder_ctrl.sv
// Directed bench for byte_serial_adder_ctrl at the default 4-byte width.
module tb_byte_serial_adder_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        ctrl_sub;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic        busy;
  logic        done;
  logic [31:0] data_result;
  logic        cout;
  logic        overflow;

  int n_assert = 0;
  int n_fail   = 0;

  byte_serial_adder_ctrl #(.N_BYTES(4)) dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .ctrl_sub      (ctrl_sub),
    .data_operandA (data_operandA),
    .data_operandB (data_operandB),
    .busy          (busy),
    .done          (done),
    .data_result   (data_result),
    .cout          (cout),
    .overflow      (overflow)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: issues start in this cycle, scrambles operands after
  // accept, checks busy in cycles 1..4 and leaves the bench in the done cycle.
  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic sub, input logic [31:0] er, input logic ec, input logic eo);
    start = 1'b1; data_operandA = a; data_operandB = b; ctrl_sub = sub;
    @(negedge clock);
    start = 1'b0; data_operandA = $urandom; data_operandB = $urandom; ctrl_sub = ~sub;
    for (int k = 1; k <= 4; k++) begin
      check({tag, " busy"}, {31'b0, busy}, 32'd1);
      check({tag, " no done"}, {31'b0, done}, 32'd0);
      @(negedge clock);
    end
    check({tag, " done"}, {31'b0, done}, 32'd1);
    check({tag, " busy low"}, {31'b0, busy}, 32'd0);
    check({tag, " result"}, data_result, er);
    check({tag, " cout"}, {31'b0, cout}, {31'b0, ec});
    check({tag, " overflow"}, {31'b0, overflow}, {31'b0, eo});
  endtask

  initial begin
    // Reset with random inputs
    reset = 1'b1; start = 1'b1; ctrl_sub = 1'b1;
    data_operandA = $urandom; data_operandB = $urandom;
    repeat (3) @(negedge clock);
    check("rst busy", {31'b0, busy}, 32'd0);
    check("rst done", {31'b0, done}, 32'd0);
    check("rst result", data_result, 32'd0);
    check("rst cout", {31'b0, cout}, 32'd0);
    check("rst ovf", {31'b0, overflow}, 32'd0);
    start = 1'b0;
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      check("idle busy", {31'b0, busy}, 32'd0);
      check("idle done", {31'b0, done}, 32'd0);
    end

    do_op("carry add", 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
    @(negedge clock);
    check("post done low", {31'b0, done}, 32'd0);
    check("post busy low", {31'b0, busy}, 32'd0);
    check("result held", data_result, 32'h0000_0100);

    do_op("sovf add", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    @(negedge clock);
    do_op("wrap add", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    @(negedge clock);
    do_op("sub 5-7", 32'd5, 32'd7, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    // Back-to-back: start issued in the done cycle
    do_op("sub min-1", 32'h8000_0000, 32'd1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
    do_op("b2b sub", 32'hDEAD_BEEF, 32'd1, 1'b1, 32'hDEAD_BEEE, 1'b1, 1'b0);
    @(negedge clock);

    // Start pulses while busy are ignored
    start = 1'b1; data_operandA = 32'h1234_5678; data_operandB = 32'h1111_1111; ctrl_sub = 1'b0;
    @(negedge clock);
    start = 1'b1; data_operandA = 32'hFFFF_FFFF; data_operandB = 32'hFFFF_FFFF; ctrl_sub = 1'b1;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("ign busy", {31'b0, busy}, 32'd1);
    @(negedge clock);
    check("ign done", {31'b0, done}, 32'd1);
    check("ign result", data_result, 32'h2345_6789);
    check("ign cout", {31'b0, cout}, 32'd0);
    check("ign ovf", {31'b0, overflow}, 32'd0);
    @(negedge clock);
    check("ign no requeue", {31'b0, busy}, 32'd0);

    // Reset mid-RUN at idx=2
    start = 1'b1; data_operandA = 32'h0101_0101; data_operandB = 32'h0202_0202; ctrl_sub = 1'b0;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check("pre-rst busy", {31'b0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    check("mid rst busy", {31'b0, busy}, 32'd0);
    check("mid rst result", data_result, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      check("no done after rst", {31'b0, done}, 32'd0);
    end
    do_op("after rst", 32'd3, 32'd4, 1'b0, 32'd7, 1'b0, 1'b0);
    @(negedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
